// File: rtl/ldpc_stream_framer.sv
// rtl/ldpc_stream_framer.sv - Valid/ready packet framer around the ldpc_decoder core
// Optional LDPC_FRAMER_STATS_EN adds saturating frame/failure counters.
module ldpc_stream_framer #(
    parameter int MAX_BLOCK_SIZE = 64,
    parameter int MAX_ROWS       = 18,
    parameter int MAX_COLS       = 32,
    parameter int MAX_ITERATIONS = 50,
    parameter int WIDTH_BLOCK    = $clog2(MAX_BLOCK_SIZE),
    parameter int NCONF          = (MAX_ROWS * MAX_COLS * WIDTH_BLOCK + MAX_BLOCK_SIZE - 1) / MAX_BLOCK_SIZE
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      s_valid,
    output logic                                      s_ready,
    input  logic [MAX_BLOCK_SIZE-1:0]                 s_data,
    input  logic                                      s_sop,
    input  logic                                      s_type,
    output logic                                      m_valid,
    input  logic                                      m_ready,
    output logic [MAX_BLOCK_SIZE-1:0]                 m_data,
    output logic                                      m_last,
    output logic                                      m_status,
    output logic                                      cfg_valid,
    output logic                                      cfg_err,
    output logic                                      pkt_drop,
    output logic [MAX_ROWS*MAX_COLS*WIDTH_BLOCK-1:0]  core_h_matrix,
    output logic [7:0]                                core_rows,
    output logic [7:0]                                core_cols,
    output logic [7:0]                                core_iterations,
    output logic [7:0]                                core_block_size,
    output logic [MAX_COLS*MAX_BLOCK_SIZE-1:0]        core_codeword,
    output logic                                      core_start,
    input  logic                                      core_busy,
    input  logic                                      core_done,
    input  logic                                      core_success,
    input  logic [MAX_COLS*MAX_BLOCK_SIZE-1:0]        core_estimate,
    output logic [15:0]                               stat_frames,
    output logic [15:0]                               stat_fails
);
    localparam int MBS     = MAX_BLOCK_SIZE;
    localparam int H_W     = MAX_ROWS * MAX_COLS * WIDTH_BLOCK;
    localparam int H_PAD   = NCONF * MBS;
    localparam int CW_W    = MAX_COLS * MBS;
    localparam int CNT_MAX = (NCONF > MAX_COLS) ? NCONF : MAX_COLS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int OUT_W   = $clog2(MAX_COLS + 1);

    typedef enum logic [1:0] {IDLE, CONF_LOAD, CODE_LOAD, LAUNCH} in_state_t;

    in_state_t          state;
    logic [CNT_W-1:0]   cnt;
    logic               discard;
    logic [H_PAD-1:0]   h_q;
    logic [CW_W-1:0]    est_q;
    logic [OUT_W-1:0]   out_idx;
    logic               xfer;
    logic               hdr_ok;
    logic [31:0]        hdr_rows, hdr_cols, hdr_iter, hdr_bs;

    // Top bs bits of a bus word, packed at chunk position idx
    function automatic logic [CW_W-1:0] place_chunk(input logic [MBS-1:0] word, input int idx,
                                                    input logic [7:0] bs);
        logic [CW_W-1:0] chunk;
        chunk = CW_W'(word >> (MBS - int'(bs)));
        return chunk << (idx * int'(bs));
    endfunction

    function automatic logic [MBS-1:0] out_beat(input logic [CW_W-1:0] est, input int idx,
                                                input logic [7:0] cols, input logic [7:0] bs);
        logic [MBS-1:0] mask;
        logic [MBS-1:0] chunk;
        mask  = {MBS{1'b1}} >> (MBS - int'(bs));
        chunk = MBS'(est >> (idx * int'(bs))) & mask;
        if (idx >= int'(cols))
            chunk = '0;
        return chunk << (MBS - int'(bs));
    endfunction

    assign s_ready  = rst_n && (state != LAUNCH) && !core_busy && !m_valid;
    assign xfer     = s_valid && s_ready;
    assign hdr_rows = {24'd0, s_data[7:0]};
    assign hdr_cols = {24'd0, s_data[15:8]};
    assign hdr_iter = {24'd0, s_data[23:16]};
    assign hdr_bs   = {24'd0, s_data[31:24]};
    assign hdr_ok   = (hdr_rows >= 32'd1) && (hdr_rows <= MAX_ROWS) &&
                      (hdr_cols > hdr_rows) && (hdr_cols <= MAX_COLS) &&
                      (hdr_iter >= 32'd1) && (hdr_iter <= MAX_ITERATIONS) &&
                      (hdr_bs >= 32'd1) && (hdr_bs <= MBS);
    assign core_h_matrix = h_q[H_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            discard         <= 1'b0;
            h_q             <= '0;
            cfg_valid       <= 1'b0;
            cfg_err         <= 1'b0;
            pkt_drop        <= 1'b0;
            core_start      <= 1'b0;
            core_rows       <= '0;
            core_cols       <= '0;
            core_iterations <= '0;
            core_block_size <= '0;
            core_codeword   <= '0;
        end else begin
            pkt_drop   <= 1'b0;
            core_start <= 1'b0;
            if (state == LAUNCH) begin
                state <= IDLE;
            end else if (xfer && s_sop) begin
                // A start-of-packet word always restarts framing, aborting any partial load
                if (state != IDLE)
                    pkt_drop <= 1'b1;
                if (!s_type) begin
                    cfg_valid <= 1'b0;
                    cnt       <= '0;
                    state     <= CONF_LOAD;
                    if (hdr_ok) begin
                        cfg_err         <= 1'b0;
                        discard         <= 1'b0;
                        core_rows       <= s_data[7:0];
                        core_cols       <= s_data[15:8];
                        core_iterations <= s_data[23:16];
                        core_block_size <= s_data[31:24];
                    end else begin
                        cfg_err  <= 1'b1;
                        discard  <= 1'b1;
                        pkt_drop <= 1'b1;
                    end
                end else begin
                    cnt           <= CNT_W'(1);
                    state         <= CODE_LOAD;
                    discard       <= !cfg_valid;
                    core_codeword <= cfg_valid ? place_chunk(s_data, 0, core_block_size) : '0;
                    if (!cfg_valid)
                        pkt_drop <= 1'b1;
                end
            end else if (xfer && state == CONF_LOAD) begin
                if (!discard)
                    h_q[cnt*MBS +: MBS] <= s_data;
                if (cnt == CNT_W'(NCONF - 1)) begin
                    cfg_valid <= !discard;
                    state     <= IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (xfer && state == CODE_LOAD) begin
                if (!discard && (int'(cnt) < int'(core_cols)))
                    core_codeword <= core_codeword | place_chunk(s_data, int'(cnt), core_block_size);
                if (cnt == CNT_W'(MAX_COLS - 1)) begin
                    state      <= discard ? IDLE : LAUNCH;
                    core_start <= !discard;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Output beats are registered so m_data/m_last/m_status stay frozen under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            est_q    <= '0;
            out_idx  <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_last   <= 1'b0;
            m_status <= 1'b0;
        end else if (core_done) begin
            est_q    <= core_estimate;
            m_status <= core_success;
            m_valid  <= 1'b1;
            out_idx  <= '0;
            m_data   <= out_beat(core_estimate, 0, core_cols, core_block_size);
            m_last   <= (MAX_COLS == 1);
        end else if (m_valid && m_ready) begin
            if (m_last) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                m_data  <= '0;
            end else begin
                out_idx <= out_idx + 1'b1;
                m_data  <= out_beat(est_q, int'(out_idx) + 1, core_cols, core_block_size);
                m_last  <= (int'(out_idx) + 1 == MAX_COLS - 1);
            end
        end
    end

`ifdef LDPC_FRAMER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frames <= '0;
            stat_fails  <= '0;
        end else if (core_done) begin
            if (stat_frames != 16'hFFFF)
                stat_frames <= stat_frames + 16'd1;
            if (!core_success && stat_fails != 16'hFFFF)
                stat_fails <= stat_fails + 16'd1;
        end
    end
`else
    assign stat_frames = '0;
    assign stat_fails  = '0;
`endif

endmodule

// File: tb/tb_ldpc_stream_framer.sv
// tb/tb_ldpc_stream_framer.sv - Randomized self-checking bench for ldpc_stream_framer
`timescale 1ns/1ps
module tb_ldpc_stream_framer;
    localparam int MBS   = 64;
    localparam int MR    = 18;
    localparam int MC    = 32;
    localparam int MI    = 50;
    localparam int WB    = 6;
    localparam int NCONF = (MR * MC * WB + MBS - 1) / MBS;
    localparam int HW    = MR * MC * WB;
    localparam int CWW   = MC * MBS;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            s_valid = 1'b0, s_ready, s_sop = 1'b0, s_type = 1'b0;
    logic [MBS-1:0]  s_data = '0;
    logic            m_valid, m_ready = 1'b0, m_last, m_status;
    logic [MBS-1:0]  m_data;
    logic            cfg_valid, cfg_err, pkt_drop, core_start;
    logic [HW-1:0]   core_h_matrix;
    logic [7:0]      core_rows, core_cols, core_iterations, core_block_size;
    logic [CWW-1:0]  core_codeword;
    logic            core_busy = 1'b0, core_done = 1'b0, core_success = 1'b0;
    logic [CWW-1:0]  core_estimate = '0;
    logic [15:0]     stat_frames, stat_fails;

    ldpc_stream_framer dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sop(s_sop), .s_type(s_type),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_status(m_status),
        .cfg_valid(cfg_valid), .cfg_err(cfg_err), .pkt_drop(pkt_drop),
        .core_h_matrix(core_h_matrix), .core_rows(core_rows), .core_cols(core_cols),
        .core_iterations(core_iterations), .core_block_size(core_block_size),
        .core_codeword(core_codeword), .core_start(core_start), .core_busy(core_busy),
        .core_done(core_done), .core_success(core_success), .core_estimate(core_estimate),
        .stat_frames(stat_frames), .stat_fails(stat_fails)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int starts = 0;

    logic [63:0]    h_words [NCONF];
    logic [63:0]    cw_words [MC];
    logic [CWW-1:0] est;
    logic [HW-1:0]  exp_h;
    int             cfg_cols, cfg_bs;
    logic [63:0]    got_beat [MC];
    logic           got_last [MC];
    logic           got_status;
    int             got_n, stall_bad;

    always @(negedge clk) begin
        if (core_start) starts++;
        if (rst_n && core_busy) begin
            checks++;
            if (s_ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_while_busy got %b want 0", s_ready);
            end
        end
    end

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [63:0] hdr(input int r, input int c, input int it, input int bs);
        logic [31:0] up;
        up = $urandom();
        return {up, 8'(bs), 8'(it), 8'(c), 8'(r)};
    endfunction

    function automatic bit legal(input int r, input int c, input int it, input int bs);
        return (r >= 1) && (r <= MR) && (c > r) && (c <= MC) &&
               (it >= 1) && (it <= MI) && (bs >= 1) && (bs <= MBS);
    endfunction

    function automatic logic [HW-1:0] model_h();
        logic [HW-1:0] r;
        r = '0;
        for (int k = 0; k < NCONF; k++)
            for (int b = 0; b < 64; b++)
                if (k * 64 + b < HW) r[k*64+b] = h_words[k][b];
        return r;
    endfunction

    function automatic logic [CWW-1:0] model_codeword(input int cols, input int bs);
        logic [CWW-1:0] r;
        r = '0;
        for (int i = 0; i < cols; i++)
            for (int b = 0; b < bs; b++)
                r[i*bs+b] = cw_words[i][MBS-bs+b];
        return r;
    endfunction

    function automatic logic [63:0] model_beat(input int idx, input int cols, input int bs);
        logic [63:0] r;
        r = '0;
        if (idx < cols)
            for (int b = 0; b < bs; b++)
                r[MBS-bs+b] = est[idx*bs+b];
        return r;
    endfunction

    task automatic send_word(input logic [63:0] d, input logic sop, input logic typ, input bit gaps);
        bit done;
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        s_data = d; s_sop = sop; s_type = typ; s_valid = 1'b1;
        done = 1'b0; n = 0;
        while (!done && n < 200) begin
            #1;
            done = s_ready;
            @(posedge clk); #1;
            n++;
        end
        s_valid = 1'b0; s_sop = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout got s_ready=0 want 1");
        end
    endtask

    task automatic load_config(input int r, input int c, input int it, input int bs, input bit gaps);
        send_word(hdr(r, c, it, bs), 1'b1, 1'b0, gaps);
        for (int k = 0; k < NCONF; k++) begin
            h_words[k] = rand64();
            send_word(h_words[k], 1'b0, 1'b0, gaps);
        end
        cfg_cols = c; cfg_bs = bs;
    endtask

    task automatic send_codeword(input bit gaps);
        for (int i = 0; i < MC; i++)
            send_word(cw_words[i], i == 0, 1'b1, gaps);
    endtask

    task automatic rand_est();
        for (int k = 0; k < CWW / 32; k++) est[k*32 +: 32] = $urandom();
    endtask

    task automatic core_finish(input bit succ);
        core_busy = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        core_estimate = est; core_success = succ; core_done = 1'b1; core_busy = 1'b0;
        @(posedge clk); #1;
        core_done = 1'b0;
    endtask

    task automatic drain_output(input int mode);
        logic [63:0] pd;
        logic pl, ps, pstall;
        int n;
        got_n = 0; stall_bad = 0; pstall = 1'b0; n = 0; pd = '0; pl = 1'b0; ps = 1'b0;
        while (got_n < MC && n < 400) begin
            m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((n % 2) == 1) : 1'($urandom_range(0, 1));
            #1;
            if (pstall && (m_valid !== 1'b1 || m_data !== pd || m_last !== pl || m_status !== ps))
                stall_bad++;
            if (m_valid && m_ready) begin
                got_beat[got_n] = m_data; got_last[got_n] = m_last; got_status = m_status;
                got_n++;
            end
            pstall = m_valid && !m_ready; pd = m_data; pl = m_last; ps = m_status;
            @(posedge clk); #1;
            n++;
        end
        m_ready = 1'b0;
    endtask

    task automatic run_frame(input bit succ);
        for (int i = 0; i < MC; i++) cw_words[i] = rand64();
        send_codeword(1'b0);
        rand_est();
        core_finish(succ);
        drain_output(0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({m_valid, m_last, m_status, cfg_valid, cfg_err, pkt_drop, core_start, s_ready} !== 8'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000000",
                {m_valid, m_last, m_status, cfg_valid, cfg_err, pkt_drop, core_start, s_ready});
        end
        checks++; if (m_data !== 64'h0 || core_h_matrix !== '0 || core_codeword !== '0) begin
            errors++; $display("FAIL reset_data got m_data=%h h_lo=%h cw_lo=%h want 0", m_data,
                core_h_matrix[63:0], core_codeword[63:0]);
        end
        checks++; if ({core_rows, core_cols, core_iterations, core_block_size, stat_frames, stat_fails} !== 64'h0) begin
            errors++; $display("FAIL reset_cfg got %h want 0",
                {core_rows, core_cols, core_iterations, core_block_size, stat_frames, stat_fails});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_config();
        send_word(hdr(4, 8, 50, 16), 1'b1, 1'b0, 1'b1);
        checks++; if (cfg_err !== 1'b0 || cfg_valid !== 1'b0) begin
            errors++; $display("FAIL cfg_hdr got err=%b valid=%b want 0 0", cfg_err, cfg_valid);
        end
        for (int k = 0; k < NCONF; k++) begin
            h_words[k] = rand64();
            send_word(h_words[k], 1'b0, 1'b0, 1'b1);
            if (k == NCONF - 2) begin
                checks++; if (cfg_valid !== 1'b0) begin
                    errors++; $display("FAIL cfg_early got %b want 0", cfg_valid);
                end
            end
        end
        cfg_cols = 8; cfg_bs = 16;
        checks++; if (cfg_valid !== 1'b1) begin
            errors++; $display("FAIL cfg_valid got %b want 1", cfg_valid);
        end
        exp_h = model_h();
        checks++; if (core_h_matrix !== exp_h) begin
            errors++; $display("FAIL cfg_hmatrix got lo=%h want lo=%h", core_h_matrix[63:0], exp_h[63:0]);
        end
        checks++; if ({core_rows, core_cols, core_iterations, core_block_size} !== {8'd4, 8'd8, 8'd50, 8'd16}) begin
            errors++; $display("FAIL cfg_fields got %h want 04083210",
                {core_rows, core_cols, core_iterations, core_block_size});
        end
    endtask

    task automatic test_codeword();
        int s0;
        logic [CWW-1:0] exp_cw;
        cw_words[0] = 64'hABCD_0000_0000_0000;
        for (int i = 1; i < MC; i++) cw_words[i] = rand64();
        s0 = starts;
        send_codeword(1'b1);
        core_busy = 1'b1;
        checks++; if (core_start !== 1'b1) begin
            errors++; $display("FAIL cw_start_latency got %b want 1", core_start);
        end
        exp_cw = model_codeword(8, 16);
        checks++; if (core_codeword[15:0] !== 16'hABCD) begin
            errors++; $display("FAIL cw_chunk0 got %h want abcd", core_codeword[15:0]);
        end
        checks++; if (core_codeword[CWW-1:128] !== '0 || core_codeword !== exp_cw) begin
            errors++; $display("FAIL cw_packed got lo=%h want lo=%h", core_codeword[127:64], exp_cw[127:64]);
        end
        @(posedge clk); #1;
        checks++; if (core_start !== 1'b0 || starts - s0 != 1) begin
            errors++; $display("FAIL cw_start_pulse got start=%b count=%0d want 0 1", core_start, starts - s0);
        end
    endtask

    task automatic test_output();
        int bad, lastbad;
        rand_est();
        est[15:0] = 16'h1234;
        core_finish(1'b1);
        checks++; if (m_valid !== 1'b1) begin
            errors++; $display("FAIL out_valid got %b want 1", m_valid);
        end
        drain_output(1);
        checks++; if (got_n != MC) begin
            errors++; $display("FAIL out_count got %0d want %0d", got_n, MC);
        end
        checks++; if (got_beat[0] !== 64'h1234_0000_0000_0000) begin
            errors++; $display("FAIL out_beat0 got %h want 1234000000000000", got_beat[0]);
        end
        bad = 0; lastbad = 0;
        for (int i = 0; i < got_n; i++) begin
            if (got_beat[i] !== model_beat(i, 8, 16) || (i >= 8 && got_beat[i] !== 64'h0)) bad++;
            if (got_last[i] !== (i == MC - 1)) lastbad++;
        end
        checks++; if (bad != 0) begin
            errors++; $display("FAIL out_beats got %0d bad want 0", bad);
        end
        checks++; if (lastbad != 0) begin
            errors++; $display("FAIL out_last got %0d bad want 0", lastbad);
        end
        checks++; if (stall_bad != 0 || got_status !== 1'b1) begin
            errors++; $display("FAIL out_stall got stall_bad=%0d status=%b want 0 1", stall_bad, got_status);
        end
        checks++; if (m_valid !== 1'b0) begin
            errors++; $display("FAIL out_done got %b want 0", m_valid);
        end
    endtask

    task automatic test_header_rules();
        int tr[12], tc[12], ti[12], tbs[12];
        bit ok;
        tr[0] = 18; tc[0] = 32; ti[0] = 50; tbs[0] = 64;
        tr[1] = 1;  tc[1] = 2;  ti[1] = 1;  tbs[1] = 1;
        tr[2] = 18; tc[2] = 18; ti[2] = 10; tbs[2] = 8;
        tr[3] = 4;  tc[3] = 33; ti[3] = 10; tbs[3] = 8;
        tr[4] = 4;  tc[4] = 8;  ti[4] = 51; tbs[4] = 16;
        tr[5] = 4;  tc[5] = 8;  ti[5] = 50; tbs[5] = 65;
        tr[6] = 19; tc[6] = 32; ti[6] = 10; tbs[6] = 8;
        tr[7] = 4;  tc[7] = 8;  ti[7] = 0;  tbs[7] = 16;
        for (int i = 8; i < 12; i++) begin
            tr[i] = $urandom_range(0, 20); tc[i] = $urandom_range(0, 34);
            ti[i] = $urandom_range(0, 52); tbs[i] = $urandom_range(0, 66);
        end
        for (int i = 0; i < 12; i++) begin
            ok = legal(tr[i], tc[i], ti[i], tbs[i]);
            send_word(hdr(tr[i], tc[i], ti[i], tbs[i]), 1'b1, 1'b0, 1'b0);
            checks++; if (cfg_err !== !ok || cfg_valid !== 1'b0 || pkt_drop !== (i > 0 || !ok)) begin
                errors++; $display("FAIL hdr_rule%0d got err=%b valid=%b drop=%b want %b 0 %b", i,
                    cfg_err, cfg_valid, pkt_drop, !ok, (i > 0 || !ok));
            end
        end
        for (int k = 0; k < NCONF; k++) begin
            h_words[k] = rand64();
            send_word(h_words[k], 1'b0, 1'b0, 1'b0);
        end
        checks++; if (cfg_valid !== legal(tr[11], tc[11], ti[11], tbs[11])) begin
            errors++; $display("FAIL hdr_final got %b want %b", cfg_valid, legal(tr[11], tc[11], ti[11], tbs[11]));
        end
    endtask

    task automatic test_bad_header();
        int s0;
        send_word(hdr(0, 8, 50, 16), 1'b1, 1'b0, 1'b0);
        checks++; if (cfg_err !== 1'b1 || cfg_valid !== 1'b0 || pkt_drop !== 1'b1) begin
            errors++; $display("FAIL bad_hdr got err=%b valid=%b drop=%b want 1 0 1", cfg_err, cfg_valid, pkt_drop);
        end
        for (int k = 0; k < NCONF; k++) send_word(rand64(), 1'b0, 1'b0, 1'b1);
        checks++; if (cfg_valid !== 1'b0 || cfg_err !== 1'b1) begin
            errors++; $display("FAIL bad_hdr_end got valid=%b err=%b want 0 1", cfg_valid, cfg_err);
        end
        s0 = starts;
        for (int i = 0; i < MC; i++) cw_words[i] = rand64();
        send_word(cw_words[0], 1'b1, 1'b1, 1'b0);
        checks++; if (pkt_drop !== 1'b1) begin
            errors++; $display("FAIL bad_cw_drop got %b want 1", pkt_drop);
        end
        for (int i = 1; i < MC; i++) send_word(cw_words[i], 1'b0, 1'b1, 1'b0);
        repeat (5) begin @(posedge clk); #1; end
        checks++; if (starts != s0 || s_ready !== 1'b1) begin
            errors++; $display("FAIL bad_cw_start got starts=%0d ready=%b want 0 1", starts - s0, s_ready);
        end
    endtask

    task automatic test_random_frames();
        int r, c, it, bs, bad;
        bit succ;
        logic [CWW-1:0] exp_cw;
        for (int f = 0; f < 3; f++) begin
            r = $urandom_range(1, MR - 1); c = $urandom_range(r + 1, MC);
            it = $urandom_range(1, MI); bs = $urandom_range(1, MBS);
            load_config(r, c, it, bs, 1'b1);
            exp_h = model_h();
            checks++; if (cfg_valid !== 1'b1 || core_h_matrix !== exp_h) begin
                errors++; $display("FAIL rnd_cfg%0d got valid=%b h_lo=%h want 1 %h", f, cfg_valid,
                    core_h_matrix[63:0], exp_h[63:0]);
            end
            for (int i = 0; i < MC; i++) cw_words[i] = rand64();
            send_codeword(1'b1);
            exp_cw = model_codeword(c, bs);
            checks++; if (core_start !== 1'b1 || core_codeword !== exp_cw) begin
                errors++; $display("FAIL rnd_cw%0d got start=%b lo=%h want 1 %h", f, core_start,
                    core_codeword[63:0], exp_cw[63:0]);
            end
            rand_est();
            succ = 1'($urandom_range(0, 1));
            core_finish(succ);
            drain_output(2);
            bad = 0;
            for (int i = 0; i < got_n; i++)
                if (got_beat[i] !== model_beat(i, c, bs) || got_last[i] !== (i == MC - 1)) bad++;
            checks++; if (got_n != MC || bad != 0 || stall_bad != 0 || got_status !== succ) begin
                errors++; $display("FAIL rnd_out%0d got n=%0d bad=%0d stall=%0d status=%b want %0d 0 0 %b",
                    f, got_n, bad, stall_bad, got_status, MC, succ);
            end
        end
    endtask

    task automatic test_abort();
        int s0;
        logic [CWW-1:0] exp_cw;
        load_config(4, 8, 50, 16, 1'b0);
        s0 = starts;
        for (int i = 0; i < 10; i++) send_word(rand64(), i == 0, 1'b1, 1'b1);
        for (int i = 0; i < MC; i++) cw_words[i] = rand64();
        send_word(cw_words[0], 1'b1, 1'b1, 1'b0);
        checks++; if (pkt_drop !== 1'b1) begin
            errors++; $display("FAIL abort_drop got %b want 1", pkt_drop);
        end
        for (int i = 1; i < MC; i++) send_word(cw_words[i], 1'b0, 1'b1, 1'b1);
        exp_cw = model_codeword(8, 16);
        checks++; if (core_start !== 1'b1 || core_codeword !== exp_cw) begin
            errors++; $display("FAIL abort_cw got start=%b lo=%h want 1 %h", core_start,
                core_codeword[63:0], exp_cw[63:0]);
        end
        rand_est();
        core_finish(1'b1);
        drain_output(0);
        checks++; if (starts - s0 != 1) begin
            errors++; $display("FAIL abort_starts got %0d want 1", starts - s0);
        end
    endtask

    task automatic test_reset_mid();
        load_config(4, 8, 50, 16, 1'b0);
        for (int i = 0; i < 5; i++) send_word(rand64(), i == 0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if ({m_valid, cfg_valid, cfg_err, pkt_drop, core_start, s_ready} !== 6'b0 ||
                      core_codeword !== '0 || core_h_matrix !== '0 || core_cols !== 8'd0) begin
            errors++; $display("FAIL mid_reset got flags=%b cw_lo=%h cols=%0d want 0",
                {m_valid, cfg_valid, cfg_err, pkt_drop, core_start, s_ready}, core_codeword[63:0], core_cols);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_config(4, 8, 50, 16, 1'b0);
        run_frame(1'b1);
        run_frame(1'b0);
        run_frame(1'b1);
`ifdef LDPC_FRAMER_STATS_EN
        checks++; if (stat_frames !== 16'd3 || stat_fails !== 16'd1) begin
            errors++; $display("FAIL stats got frames=%0d fails=%0d want 3 1", stat_frames, stat_fails);
        end
`else
        checks++; if (stat_frames !== 16'd0 || stat_fails !== 16'd0) begin
            errors++; $display("FAIL stats got frames=%0d fails=%0d want 0 0", stat_frames, stat_fails);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_config();
        test_codeword();
        test_output();
        test_header_rules();
        test_bad_header();
        test_random_frames();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
